// File: rtl/sound_gen_pkg.sv
// Shared constants for the sound-generator sample path: sequencer state
// encoding, status-word bit positions and the rate-divider clamp.
package sound_gen_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PRIME = 2'd1;
   localparam logic [1:0] ST_PLAY  = 2'd2;

   localparam int ST_STATE_HI = 31;
   localparam int ST_STATE_LO = 30;
   localparam int ST_UNDERRUN = 29;
   localparam int ST_OVERFLOW = 28;

   // A divider of 0 behaves like 1: one sample per clock.
   function automatic logic [31:0] eff_div(input logic [31:0] rate_div);
      return (rate_div == 32'd0) ? 32'd1 : rate_div;
   endfunction

endpackage

// File: rtl/pipe_stream_sequencer_if.sv
// Host pipe and sample-output bundle of the stream sequencer; the host side
// drives the master modport, the sequencer sits on the slave modport.
interface pipe_stream_sequencer_if #(
   parameter int AW = 10
);
   logic        ep_write;
   logic [31:0] ep_dataout;
   logic        ep_read;
   logic [31:0] ep_datain;
   logic [31:0] rate_div;
   logic        run;
   logic        sample_valid;
   logic [31:0] sample_data;
   logic [AW:0] fifo_level;

   modport master (
      output ep_write, ep_dataout, ep_read, rate_div, run,
      input  ep_datain, sample_valid, sample_data, fifo_level
   );

   modport slave (
      input  ep_write, ep_dataout, ep_read, rate_div, run,
      output ep_datain, sample_valid, sample_data, fifo_level
   );
endinterface

// File: rtl/stream_fifo.sv
// Single-clock FIFO of 32-bit words with the head word presented combinationally.
// A write into a full FIFO is accepted only when a pop happens in the same cycle.
module stream_fifo #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   output logic [31:0]   rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          push_s, pop_s;

   assign empty   = (level_q == {(AW+1){1'b0}});
   assign full    = (level_q == LVL_FULL);
   assign pop_s   = rd_en && !empty;
   assign push_s  = wr_en && (!full || pop_s);
   assign rd_data = mem_q[rd_ptr_q];
   assign level   = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_s) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end
endmodule

// File: rtl/pipe_stream_sequencer.sv
// Buffers host pipe-in samples and releases them at a programmed rate, reporting
// state, sticky over/underrun flags and fill level on the pipe-out status word.
module pipe_stream_sequencer
   import sound_gen_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int AW          = 10,
   parameter int PRIME_LEVEL = 512
) (
   input  logic                   okClk,
   input  logic                   mst_reset,
   pipe_stream_sequencer_if.slave bus
);
   localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME_LEVEL);

   logic [1:0]  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        underrun_q, underrun_d;
   logic        overflow_q, overflow_d;
   logic        valid_q, valid_d;
   logic [31:0] data_q, data_d;
   logic [31:0] status_q, status_d;

   logic        full_s, empty_s, tick_s, pop_s;
   logic [AW:0] level_s;
   logic [31:0] head_s, div_s;

   stream_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk     (okClk),
      .rst     (mst_reset),
      .wr_en   (bus.ep_write),
      .wr_data (bus.ep_dataout),
      .rd_en   (pop_s),
      .rd_data (head_s),
      .full    (full_s),
      .empty   (empty_s),
      .level   (level_s)
   );

   // Ticks are gated by run so nothing is released once the host stops playback.
   assign div_s  = eff_div(bus.rate_div);
   assign tick_s = (state_q == ST_PLAY) && bus.run && (cnt_q >= div_s - 32'd1);
   assign pop_s  = tick_s && !empty_s;

   always_comb begin
      state_d = state_q;
      if (!bus.run) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  state_d = ST_PRIME;
            ST_PRIME: begin
               if (level_s >= PRIME_LVL) state_d = ST_PLAY;
               else                      state_d = ST_PRIME;
            end
            ST_PLAY:  state_d = ST_PLAY;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d = 32'd0;
      if (state_q == ST_PLAY && state_d == ST_PLAY) begin
         if (cnt_q >= div_s - 32'd1) cnt_d = 32'd0;
         else                        cnt_d = cnt_q + 32'd1;
      end else begin
         cnt_d = 32'd0;
      end
   end

   // Sticky flags: a new event in the read cycle wins over the clear.
   always_comb begin
      underrun_d = underrun_q;
      overflow_d = overflow_q;
      if (bus.ep_read) begin
         underrun_d = 1'b0;
         overflow_d = 1'b0;
      end else begin
         underrun_d = underrun_q;
         overflow_d = overflow_q;
      end
      if (tick_s && empty_s)                  underrun_d = 1'b1;
      else                                    underrun_d = underrun_d;
      if (bus.ep_write && full_s && !pop_s)   overflow_d = 1'b1;
      else                                    overflow_d = overflow_d;
   end

   always_comb begin
      valid_d = tick_s;
      data_d  = 32'd0;
      if (pop_s) data_d = head_s;
      else       data_d = 32'd0;
      status_d = 32'd0;
      status_d[ST_STATE_HI:ST_STATE_LO] = state_q;
      status_d[ST_UNDERRUN]             = underrun_q;
      status_d[ST_OVERFLOW]             = overflow_q;
      status_d[AW:0]                    = level_s;
   end

   always_ff @(posedge okClk) begin
      if (mst_reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 32'd0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= 32'd0;
         status_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         status_q   <= status_d;
      end
   end

   assign bus.sample_valid = valid_q;
   assign bus.sample_data  = data_q;
   assign bus.ep_datain    = status_q;
   assign bus.fifo_level   = level_s;
endmodule
